gate_truth_checker: RTL and testbench

Sequential exhaustive tester for a 2-input gate primitive. It drives all four `{a,b}` input combinations into a device under test and samples the DUT output after a programmable settle time. Each sample is compared against a parameterised expected truth table, and per-sweep pass/fail, a mismatch mask and running counters are reported. It sits on the input side of any 2-input gate/UDP instance, driving its inputs and reading its output, in single-shot or continuous self-check mode.

---
 rtl/gate_truth_checker.sv | 218 +++++++++++++++++++++
 tb/tb_gate_truth_checker.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_truth_checker.sv
// gate_truth_checker
//
// Sequential exhaustive tester for a 2-input gate primitive. It steps the
// target gate through all four {a,b} input combinations. Each vector is held
// for SETTLE+1 cycles. At the last edge of each vector the gate output is
// compared against the expected truth table TRUTH. Every completed sweep
// reports a mismatch mask and a pass flag, and two running counters are kept.
//
// Parameters
//   TRUTH     expected gate output for vector i = {a,b} in bit i (default AND)
//   SETTLE    extra hold cycles per vector before sampling (0..15)
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      begins a run when seen high in IDLE
//   cont       sampled with start; 1 = repeat sweeps until stopped
//   stop       end-of-run request, honoured at the end of the current sweep
//   a_out      registered gate input a (vector bit 1)
//   b_out      registered gate input b (vector bit 0)
//   o_in       gate output under test
//   busy       run in progress (state other than IDLE)
//   done       one-cycle pulse per completed sweep
//   pass       last completed sweep had no mismatch
//   err_mask   per-vector mismatch flags of the last completed sweep
//   sweep_cnt  sweeps completed since start (wraps)
//   err_cnt    mismatches since start (saturates at 255)
//
// State table
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | inputs parked at 0, waiting for start
//   ST_DRIVE | vector vec_idx applied, settle timer counting down
//   ST_DONE  | one-cycle result publish, choose next sweep or IDLE

`timescale 1ns/1ps

module gate_truth_checker #(
  parameter logic [3:0]  TRUTH  = 4'b1000,
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  input  logic       stop,
  output logic       a_out,
  output logic       b_out,
  input  logic       o_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_mask,
  output logic [7:0] sweep_cnt,
  output logic [7:0] err_cnt
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic [1:0] vec_idx;
  logic [1:0] vec_nxt;
  logic [3:0] settle_tmr;
  logic [3:0] work_mask;
  logic [3:0] mask_upd;
  logic       cont_lat;
  logic       stop_pend;

  logic       tmr_tc;
  logic       sample_now;
  logic       last_vec;
  logic       mismatch;
  logic       sweep_end;
  logic       restart;

  // Timer terminal count marks the final edge of the current vector.
  assign tmr_tc     = (settle_tmr == 4'd0);
  assign sample_now = (state == ST_DRIVE) && tmr_tc;
  assign last_vec   = (vec_idx == 2'd3);
  assign vec_nxt    = vec_idx + 2'd1;
  assign mismatch   = (o_in != TRUTH[vec_idx]);
  assign sweep_end  = sample_now && last_vec;
  assign restart    = (state == ST_DONE) && (state_nxt == ST_DRIVE);

  // Working mask including the vector being sampled this cycle, so the
  // final vector's result lands in err_mask on the same edge.
  always_comb begin
    mask_upd = work_mask;
    if (mismatch) begin
      mask_upd[vec_idx] = 1'b1;
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (sweep_end) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        // A stop arriving in the DONE cycle itself also ends the run.
        if (cont_lat && !stop_pend && !stop) begin
          state_nxt = ST_DRIVE;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_idx    <= 2'd0;
      settle_tmr <= 4'd0;
      work_mask  <= 4'd0;
      cont_lat   <= 1'b0;
      stop_pend  <= 1'b0;
      a_out      <= 1'b0;
      b_out      <= 1'b0;
      pass       <= 1'b0;
      err_mask   <= 4'd0;
      sweep_cnt  <= 8'd0;
      err_cnt    <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            sweep_cnt  <= 8'd0;
            err_cnt    <= 8'd0;
            work_mask  <= 4'd0;
            cont_lat   <= cont;
            // start+stop together: exactly one sweep, whatever cont says.
            stop_pend  <= stop;
            vec_idx    <= 2'd0;
            settle_tmr <= SETTLE_LD;
            a_out      <= 1'b0;
            b_out      <= 1'b0;
          end
        end

        ST_DRIVE: begin
          if (stop) begin
            stop_pend <= 1'b1;
          end
          if (tmr_tc) begin
            if (mismatch && (err_cnt != 8'hFF)) begin
              err_cnt <= err_cnt + 8'd1;
            end
            if (last_vec) begin
              err_mask  <= mask_upd;
              pass      <= (mask_upd == 4'd0);
              sweep_cnt <= sweep_cnt + 8'd1;
              work_mask <= 4'd0;
              vec_idx   <= 2'd0;
              a_out     <= 1'b0;
              b_out     <= 1'b0;
            end else begin
              work_mask  <= mask_upd;
              vec_idx    <= vec_nxt;
              settle_tmr <= SETTLE_LD;
              a_out      <= vec_nxt[1];
              b_out      <= vec_nxt[0];
            end
          end else begin
            settle_tmr <= settle_tmr - 4'd1;
          end
        end

        ST_DONE: begin
          if (stop) begin
            stop_pend <= 1'b1;
          end
          if (restart) begin
            vec_idx    <= 2'd0;
            work_mask  <= 4'd0;
            settle_tmr <= SETTLE_LD;
            a_out      <= 1'b0;
            b_out      <= 1'b0;
          end
        end

        default: begin
          vec_idx <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_truth_checker.sv
`timescale 1ns/1ps

module tb_gate_truth_checker;

  localparam logic [3:0] TRUTH_EXP = 4'b1000;
  localparam int S   = 2;
  localparam int SW  = 4 * (S + 1);
  localparam int PER = SW + 1;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       cont  = 1'b0;
  logic       stop  = 1'b0;
  logic       o_in;
  logic       a_out;
  logic       b_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_mask;
  logic [7:0] sweep_cnt;
  logic [7:0] err_cnt;

  int mode  = 0;
  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int done_cyc;
    int mask;
    int pass;
    int errs;
    int sweeps;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  gate_truth_checker #(
    .TRUTH (TRUTH_EXP),
    .SETTLE(S)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .cont     (cont),
    .stop     (stop),
    .a_out    (a_out),
    .b_out    (b_out),
    .o_in     (o_in),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_mask (err_mask),
    .sweep_cnt(sweep_cnt),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Gate under test: 0 = AND, 1 = OR, otherwise stuck-at-1.
  function automatic logic gate_model(input int m, input logic [1:0] v);
    case (m)
      0:       return v[1] & v[0];
      1:       return v[1] | v[0];
      default: return 1'b1;
    endcase
  endfunction

  assign o_in = gate_model(mode, {a_out, b_out});

  function automatic int exp_mask(input int m);
    int mk;
    logic [1:0] v;
    mk = 0;
    for (int i = 0; i < 4; i++) begin
      v = 2'(i);
      if (gate_model(m, v) != TRUTH_EXP[i]) mk = mk | (1 << i);
    end
    return mk;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_a"},     a_out,     0);
    chk({tag, "_b"},     b_out,     0);
    chk({tag, "_busy"},  busy,      0);
    chk({tag, "_done"},  done,      0);
    chk({tag, "_pass"},  pass,      0);
    chk({tag, "_mask"},  err_mask,  0);
    chk({tag, "_sweep"}, sweep_cnt, 0);
    chk({tag, "_errs"},  err_cnt,   0);
  endtask

  // Scoreboard consumer: one expected record per done pulse.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("done_cycle", cyc,       mon_e.done_cyc);
        chk("err_mask",   err_mask,  mon_e.mask);
        chk("pass",       pass,      mon_e.pass);
        chk("err_cnt",    err_cnt,   mon_e.errs);
        chk("sweep_cnt",  sweep_cnt, mon_e.sweeps);
      end
    end
  end

  // Drives start so it is sampled at edge e; pushes n expected sweeps.
  // Returns at the negedge following edge e.
  task automatic launch(input int m, input bit c, input int n, input bit stop_now,
                        output int e);
    int   mk;
    int   ones;
    exp_t x;
    mode = m;
    mk   = exp_mask(m);
    ones = $countones(mk);
    @(negedge clk);
    e = cyc + 1;
    for (int k = 1; k <= n; k++) begin
      x.done_cyc = e + SW + (k - 1) * PER;
      x.mask     = mk;
      x.pass     = (mk == 0) ? 1 : 0;
      x.errs     = (ones * k > 255) ? 255 : ones * k;
      x.sweeps   = k % 256;
      sb.push_back(x);
    end
    start = 1'b1;
    cont  = c;
    stop  = stop_now;
    @(negedge clk);
    start = 1'b0;
    cont  = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic pulse_stop_at(input int t);
    while (cyc < t - 1) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic wait_idle(output int t);
    t = -1;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (!busy) begin
        t = cyc;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int t;

    #2;
    chk_zero_outputs("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // AND gate, single sweep, start re-pulsed mid-run.
    launch(0, 1'b0, 1, 1'b0, e);
    chk("busy_rise", busy, 1);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("vector", {a_out, b_out}, (k < 12) ? k / 3 : 0);
      chk("busy_run", busy, 1);
      if (k == 3) start = 1'b1;
      if (k == 4) start = 1'b0;
    end
    wait_idle(t);
    chk("busy_fall_and", t, e + SW + 1);

    // OR gate against AND table.
    launch(1, 1'b0, 1, 1'b0, e);
    wait_idle(t);
    chk("busy_fall_or", t, e + SW + 1);

    // Stuck-at-1, continuous, stop inside the third sweep.
    launch(2, 1'b1, 3, 1'b0, e);
    pulse_stop_at(e + 2 * PER + 4);
    wait_idle(t);
    chk("busy_fall_cont3", t, e + SW + 2 * PER + 1);

    // Stuck-at-1, 86 sweeps: error counter saturation.
    launch(2, 1'b1, 86, 1'b0, e);
    pulse_stop_at(e + 85 * PER + 4);
    wait_idle(t);
    chk("busy_fall_cont86", t, e + SW + 85 * PER + 1);

    // Asynchronous reset in the middle of a sweep.
    launch(0, 1'b0, 1, 1'b0, e);
    while (cyc < e + 5) @(negedge clk);
    chk("pre_reset_b", b_out, 1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk_zero_outputs("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    launch(0, 1'b0, 1, 1'b0, e);
    wait_idle(t);
    chk("busy_fall_post_rst", t, e + SW + 1);

    // start and stop in the same IDLE cycle with cont=1: one sweep only.
    launch(2, 1'b1, 1, 1'b1, e);
    wait_idle(t);
    chk("busy_fall_startstop", t, e + SW + 1);
    repeat (PER + 2) @(negedge clk);
    chk("idle_after_startstop", busy, 0);

    chk("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
